// File: rtl/axi_rr_arbiter.sv
// axi_rr_arbiter
// Two-master to one-slave AXI4 arbiter. M0 is the fetch unit (read only) and
// M1 is the load/store unit (read and write). One transaction at a time owns
// the slave, from its address grant until its last R beat or its B response.
// Masters alternate round-robin, and inside M1 a pending write beats a read.
// Bursts, IDs, resp, size and burst type pass through untouched.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   m0_ar*, m0_r*       M0 read address / read data channels
//   m1_ar*, m1_r*       M1 read address / read data channels
//   m1_aw*, m1_w*, m1_b* M1 write address / write data / write response
//   s_*                 the same channel set toward the slave, directions reversed
module axi_rr_arbiter #(
  parameter logic RESET_LAST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_araddr,
  input  logic [3:0]  m0_arid,
  input  logic [7:0]  m0_arlen,
  input  logic [2:0]  m0_arsize,
  input  logic [1:0]  m0_arburst,
  input  logic        m0_arvalid,
  output logic        m0_arready,
  output logic [31:0] m0_rdata,
  output logic [1:0]  m0_rresp,
  output logic [3:0]  m0_rid,
  output logic        m0_rlast,
  output logic        m0_rvalid,
  input  logic        m0_rready,
  input  logic [31:0] m1_araddr,
  input  logic [3:0]  m1_arid,
  input  logic [7:0]  m1_arlen,
  input  logic [2:0]  m1_arsize,
  input  logic [1:0]  m1_arburst,
  input  logic        m1_arvalid,
  output logic        m1_arready,
  output logic [31:0] m1_rdata,
  output logic [1:0]  m1_rresp,
  output logic [3:0]  m1_rid,
  output logic        m1_rlast,
  output logic        m1_rvalid,
  input  logic        m1_rready,
  input  logic [31:0] m1_awaddr,
  input  logic [3:0]  m1_awid,
  input  logic [7:0]  m1_awlen,
  input  logic [2:0]  m1_awsize,
  input  logic [1:0]  m1_awburst,
  input  logic        m1_awvalid,
  output logic        m1_awready,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  input  logic        m1_wlast,
  input  logic        m1_wvalid,
  output logic        m1_wready,
  output logic [1:0]  m1_bresp,
  output logic [3:0]  m1_bid,
  output logic        m1_bvalid,
  input  logic        m1_bready,
  output logic [31:0] s_araddr,
  output logic [3:0]  s_arid,
  output logic [7:0]  s_arlen,
  output logic [2:0]  s_arsize,
  output logic [1:0]  s_arburst,
  output logic        s_arvalid,
  input  logic        s_arready,
  input  logic [31:0] s_rdata,
  input  logic [1:0]  s_rresp,
  input  logic [3:0]  s_rid,
  input  logic        s_rlast,
  input  logic        s_rvalid,
  output logic        s_rready,
  output logic [31:0] s_awaddr,
  output logic [3:0]  s_awid,
  output logic [7:0]  s_awlen,
  output logic [2:0]  s_awsize,
  output logic [1:0]  s_awburst,
  output logic        s_awvalid,
  input  logic        s_awready,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  output logic        s_wlast,
  output logic        s_wvalid,
  input  logic        s_wready,
  input  logic [1:0]  s_bresp,
  input  logic [3:0]  s_bid,
  input  logic        s_bvalid,
  output logic        s_bready
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WRESP} state_t;

  state_t state_q, state_d;
  logic   grant_q, grant_d;
  logic   last_q, last_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;
  logic   m0_req, m1_req, winner, aw_hs, w_hs;

  // Next-state and channel routing. Every output defaults to 0 so that a
  // channel not owned by the current state is fully quiet on both sides.
  // IDLE drives nothing toward the slave, which keeps the master valid to
  // slave valid path registered: a grant shows up one cycle after the request.
  // In WADDR the AW and W channels run independently; each is masked once
  // its handshake is recorded so it is never presented twice.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    m0_req     = m0_arvalid;
    m1_req     = m1_awvalid | m1_arvalid;
    winner     = 1'b0;
    aw_hs      = 1'b0;
    w_hs       = 1'b0;
    m0_arready = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = '0;
    m0_rid     = '0;
    m0_rlast   = 1'b0;
    m0_rvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = '0;
    m1_rid     = '0;
    m1_rlast   = 1'b0;
    m1_rvalid  = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bresp   = '0;
    m1_bid     = '0;
    m1_bvalid  = 1'b0;
    s_araddr   = '0;
    s_arid     = '0;
    s_arlen    = '0;
    s_arsize   = '0;
    s_arburst  = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_awaddr   = '0;
    s_awid     = '0;
    s_awlen    = '0;
    s_awsize   = '0;
    s_awburst  = '0;
    s_awvalid  = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_wlast    = 1'b0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          // On a tie the master that was not granted last time wins.
          winner  = (m0_req && m1_req) ? ~last_q : m1_req;
          grant_d = winner;
          last_d  = winner;
          if (winner && m1_awvalid) begin
            state_d   = WADDR;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d = RADDR;
          end
        end
      end

      RADDR: begin
        if (grant_q) begin
          s_araddr   = m1_araddr;
          s_arid     = m1_arid;
          s_arlen    = m1_arlen;
          s_arsize   = m1_arsize;
          s_arburst  = m1_arburst;
          s_arvalid  = m1_arvalid;
          m1_arready = s_arready;
        end else begin
          s_araddr   = m0_araddr;
          s_arid     = m0_arid;
          s_arlen    = m0_arlen;
          s_arsize   = m0_arsize;
          s_arburst  = m0_arburst;
          s_arvalid  = m0_arvalid;
          m0_arready = s_arready;
        end
        if (s_arvalid && s_arready) state_d = RDATA;
      end

      RDATA: begin
        if (grant_q) begin
          m1_rdata  = s_rdata;
          m1_rresp  = s_rresp;
          m1_rid    = s_rid;
          m1_rlast  = s_rlast;
          m1_rvalid = s_rvalid;
          s_rready  = m1_rready;
        end else begin
          m0_rdata  = s_rdata;
          m0_rresp  = s_rresp;
          m0_rid    = s_rid;
          m0_rlast  = s_rlast;
          m0_rvalid = s_rvalid;
          s_rready  = m0_rready;
        end
        if (s_rvalid && s_rready && s_rlast) state_d = IDLE;
      end

      WADDR: begin
        s_awaddr   = m1_awaddr;
        s_awid     = m1_awid;
        s_awlen    = m1_awlen;
        s_awsize   = m1_awsize;
        s_awburst  = m1_awburst;
        s_awvalid  = m1_awvalid & ~aw_done_q;
        m1_awready = s_awready & ~aw_done_q;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        s_wlast    = m1_wlast;
        s_wvalid   = m1_wvalid & ~w_done_q;
        m1_wready  = s_wready & ~w_done_q;
        aw_hs      = s_awvalid & s_awready;
        w_hs       = s_wvalid & s_wready & m1_wlast;
        aw_done_d  = aw_done_q | aw_hs;
        w_done_d   = w_done_q | w_hs;
        if (aw_done_d && w_done_d) state_d = WRESP;
      end

      WRESP: begin
        m1_bresp  = s_bresp;
        m1_bid    = s_bid;
        m1_bvalid = s_bvalid;
        s_bready  = m1_bready;
        if (s_bvalid && m1_bready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State register. Reset abandons any in-flight transaction and restores
  // the round-robin pointer so the first tie after reset is deterministic.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      last_q    <= RESET_LAST;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// tb_axi_rr_arbiter
// Directed bench for axi_rr_arbiter. Each task drives one scenario cycle by
// cycle, acting as both masters and the slave, and compares DUT outputs
// against hand-computed values.
module tb_axi_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_araddr, m1_araddr, m1_awaddr, m1_wdata, s_rdata;
  logic [3:0]  m0_arid, m1_arid, m1_awid, m1_wstrb, s_rid, s_bid;
  logic [7:0]  m0_arlen, m1_arlen, m1_awlen;
  logic [2:0]  m0_arsize, m1_arsize, m1_awsize;
  logic [1:0]  m0_arburst, m1_arburst, m1_awburst, s_rresp, s_bresp;
  logic        m0_arvalid, m0_rready, m1_arvalid, m1_rready, m1_awvalid;
  logic        m1_wlast, m1_wvalid, m1_bready;
  logic        s_arready, s_rlast, s_rvalid, s_awready, s_wready, s_bvalid;

  logic        m0_arready, m0_rlast, m0_rvalid, m1_arready, m1_rlast, m1_rvalid;
  logic        m1_awready, m1_wready, m1_bvalid;
  logic [31:0] m0_rdata, m1_rdata, s_araddr, s_awaddr, s_wdata;
  logic [1:0]  m0_rresp, m1_rresp, m1_bresp, s_arburst, s_awburst;
  logic [3:0]  m0_rid, m1_rid, m1_bid, s_arid, s_awid, s_wstrb;
  logic [7:0]  s_arlen, s_awlen;
  logic [2:0]  s_arsize, s_awsize;
  logic        s_arvalid, s_rready, s_awvalid, s_wlast, s_wvalid, s_bready;

  int vec_count = 0;
  int err_count = 0;

  axi_rr_arbiter #(.RESET_LAST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arid(m0_arid), .m0_arlen(m0_arlen),
    .m0_arsize(m0_arsize), .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid),
    .m0_arready(m0_arready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m0_rid(m0_rid), .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid),
    .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arid(m1_arid), .m1_arlen(m1_arlen),
    .m1_arsize(m1_arsize), .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid),
    .m1_arready(m1_arready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .m1_rid(m1_rid), .m1_rlast(m1_rlast), .m1_rvalid(m1_rvalid),
    .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_awid(m1_awid), .m1_awlen(m1_awlen),
    .m1_awsize(m1_awsize), .m1_awburst(m1_awburst), .m1_awvalid(m1_awvalid),
    .m1_awready(m1_awready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_wlast(m1_wlast), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bid(m1_bid), .m1_bvalid(m1_bvalid),
    .m1_bready(m1_bready),
    .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arvalid(s_arvalid),
    .s_arready(s_arready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rid(s_rid), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen),
    .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awvalid(s_awvalid),
    .s_awready(s_awready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bid(s_bid), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    m0_araddr = '0; m0_arid = '0; m0_arlen = '0; m0_arsize = 3'd2; m0_arburst = 2'd1;
    m0_arvalid = 0; m0_rready = 0;
    m1_araddr = '0; m1_arid = '0; m1_arlen = '0; m1_arsize = 3'd2; m1_arburst = 2'd1;
    m1_arvalid = 0; m1_rready = 0;
    m1_awaddr = '0; m1_awid = '0; m1_awlen = '0; m1_awsize = 3'd2; m1_awburst = 2'd1;
    m1_awvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_wlast = 0; m1_wvalid = 0;
    m1_bready = 0;
    s_arready = 0; s_rdata = '0; s_rresp = '0; s_rid = '0; s_rlast = 0; s_rvalid = 0;
    s_awready = 0; s_wready = 0; s_bresp = '0; s_bid = '0; s_bvalid = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    m0_araddr = 32'h1234; m1_awaddr = 32'h5678; m1_wdata = 32'h9abc;
    s_rdata = 32'hcafe; s_rvalid = 1; s_bvalid = 1; s_bid = 4'h3;
    s_arready = 1; s_awready = 1; s_wready = 1;
    m0_rready = 1; m1_rready = 1; m1_bready = 1;
    rst = 1;
    tick();
    tick();
    rst = 0;
    #1;
    vec_count++; if (s_arvalid !== 1'b0) begin err_count++; $display("[TB] FAIL reset_s_arvalid: got %b expected 0", s_arvalid); end
    vec_count++; if (s_awvalid !== 1'b0 || s_wvalid !== 1'b0) begin err_count++; $display("[TB] FAIL reset_s_wr_valid: got aw=%b w=%b expected 0 0", s_awvalid, s_wvalid); end
    vec_count++; if (s_rready !== 1'b0 || s_bready !== 1'b0) begin err_count++; $display("[TB] FAIL reset_s_ready: got r=%b b=%b expected 0 0", s_rready, s_bready); end
    vec_count++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || m1_bvalid !== 1'b0) begin err_count++; $display("[TB] FAIL reset_m_valid: got %b%b%b expected 000", m0_rvalid, m1_rvalid, m1_bvalid); end
    vec_count++; if (m0_arready !== 1'b0 || m1_awready !== 1'b0 || m1_wready !== 1'b0) begin err_count++; $display("[TB] FAIL reset_m_ready: got %b%b%b expected 000", m0_arready, m1_awready, m1_wready); end
    vec_count++; if (s_araddr !== 32'h0 || s_awaddr !== 32'h0 || s_wdata !== 32'h0) begin err_count++; $display("[TB] FAIL reset_s_payload: got %h %h %h expected zeros", s_araddr, s_awaddr, s_wdata); end
    vec_count++; if (m0_rdata !== 32'h0 || m1_bid !== 4'h0) begin err_count++; $display("[TB] FAIL reset_m_payload: got %h %h expected zeros", m0_rdata, m1_bid); end
    idle_inputs();
  endtask

  task automatic test_m0_read;
    m0_araddr = 32'h80000000; m0_arid = 4'h2; m0_arvalid = 1; s_arready = 1;
    #1;
    vec_count++; if (s_arvalid !== 1'b0) begin err_count++; $display("[TB] FAIL m0rd_idle_arvalid: got %b expected 0", s_arvalid); end
    tick();
    vec_count++; if (s_arvalid !== 1'b1) begin err_count++; $display("[TB] FAIL m0rd_raddr_arvalid: got %b expected 1", s_arvalid); end
    vec_count++; if (s_araddr !== 32'h80000000 || s_arid !== 4'h2) begin err_count++; $display("[TB] FAIL m0rd_araddr: got %h/%h expected 80000000/2", s_araddr, s_arid); end
    vec_count++; if (m0_arready !== 1'b1 || m1_arready !== 1'b0) begin err_count++; $display("[TB] FAIL m0rd_arready: got m0=%b m1=%b expected 1 0", m0_arready, m1_arready); end
    vec_count++; if (m1_rvalid !== 1'b0) begin err_count++; $display("[TB] FAIL m0rd_m1_rvalid_a: got %b expected 0", m1_rvalid); end
    tick();
    m0_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rdata = 32'hdeadbeef; s_rid = 4'h2; s_rresp = 2'b10; s_rlast = 1;
    m0_rready = 1; m1_rready = 1;
    #1;
    vec_count++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hdeadbeef) begin err_count++; $display("[TB] FAIL m0rd_rdata: got %b/%h expected 1/deadbeef", m0_rvalid, m0_rdata); end
    vec_count++; if (m0_rid !== 4'h2 || m0_rresp !== 2'b10 || m0_rlast !== 1'b1) begin err_count++; $display("[TB] FAIL m0rd_rmeta: got %h/%b/%b expected 2/10/1", m0_rid, m0_rresp, m0_rlast); end
    vec_count++; if (s_rready !== 1'b1 || m1_rvalid !== 1'b0) begin err_count++; $display("[TB] FAIL m0rd_route: got rready=%b m1_rvalid=%b expected 1 0", s_rready, m1_rvalid); end
    tick();
    vec_count++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || s_rready !== 1'b0) begin err_count++; $display("[TB] FAIL m0rd_back_idle: got %b%b%b expected 000", m0_rvalid, m1_rvalid, s_rready); end
    idle_inputs();
  endtask

  task automatic test_round_robin;
    logic [2:0] exp_grant;
    logic       g;
    exp_grant = 3'b010;
    rst = 1;
    tick();
    rst = 0;
    m0_araddr = 32'h100; m1_araddr = 32'h200; s_arready = 1;
    m0_rready = 1; m1_rready = 1;
    for (int r = 0; r < 3; r++) begin
      g = exp_grant[r];
      m0_arvalid = 1; m1_arvalid = 1;
      tick();
      vec_count++; if (s_araddr !== (g ? 32'h200 : 32'h100)) begin err_count++; $display("[TB] FAIL rr_grant%0d: got %h expected %h", r, s_araddr, g ? 32'h200 : 32'h100); end
      tick();
      if (g) m1_arvalid = 0; else m0_arvalid = 0;
      s_rvalid = 1; s_rlast = 1; s_rdata = 32'h100 + r;
      #1;
      vec_count++; if (m0_rvalid !== ~g || m1_rvalid !== g) begin err_count++; $display("[TB] FAIL rr_route%0d: got m0=%b m1=%b expected %b %b", r, m0_rvalid, m1_rvalid, ~g, g); end
      tick();
      s_rvalid = 0; s_rlast = 0;
    end
    idle_inputs();
  endtask

  task automatic test_write_priority;
    m1_awaddr = 32'ha00003f8; m1_awid = 4'h5; m1_awvalid = 1;
    m1_wdata = 32'h41; m1_wstrb = 4'h1; m1_wlast = 1; m1_wvalid = 1;
    m1_araddr = 32'h300; m1_arid = 4'h6; m1_arvalid = 1;
    s_awready = 1; s_wready = 1; s_arready = 1; m1_bready = 1; m1_rready = 1;
    tick();
    vec_count++; if (s_awvalid !== 1'b1 || s_awaddr !== 32'ha00003f8 || s_awid !== 4'h5) begin err_count++; $display("[TB] FAIL wr_aw: got %b/%h/%h expected 1/a00003f8/5", s_awvalid, s_awaddr, s_awid); end
    vec_count++; if (s_wvalid !== 1'b1 || s_wdata !== 32'h41 || s_wstrb !== 4'h1 || s_wlast !== 1'b1) begin err_count++; $display("[TB] FAIL wr_w: got %b/%h/%h/%b expected 1/41/1/1", s_wvalid, s_wdata, s_wstrb, s_wlast); end
    vec_count++; if (s_arvalid !== 1'b0 || m1_awready !== 1'b1 || m1_wready !== 1'b1) begin err_count++; $display("[TB] FAIL wr_first: got arvalid=%b awready=%b wready=%b expected 0 1 1", s_arvalid, m1_awready, m1_wready); end
    tick();
    m1_awvalid = 0; m1_wvalid = 0; m1_wlast = 0;
    s_bvalid = 1; s_bid = 4'h5; s_bresp = 2'b11;
    #1;
    vec_count++; if (m1_bvalid !== 1'b1 || m1_bid !== 4'h5 || m1_bresp !== 2'b11) begin err_count++; $display("[TB] FAIL wr_b: got %b/%h/%b expected 1/5/11", m1_bvalid, m1_bid, m1_bresp); end
    vec_count++; if (s_arvalid !== 1'b0 || s_bready !== 1'b1) begin err_count++; $display("[TB] FAIL wr_b_before_ar: got arvalid=%b bready=%b expected 0 1", s_arvalid, s_bready); end
    tick();
    s_bvalid = 0;
    #1;
    vec_count++; if (s_arvalid !== 1'b0 || m1_bvalid !== 1'b0) begin err_count++; $display("[TB] FAIL wr_idle_gap: got arvalid=%b bvalid=%b expected 0 0", s_arvalid, m1_bvalid); end
    tick();
    vec_count++; if (s_arvalid !== 1'b1 || s_araddr !== 32'h300 || m1_arready !== 1'b1) begin err_count++; $display("[TB] FAIL wr_then_rd: got %b/%h/%b expected 1/300/1", s_arvalid, s_araddr, m1_arready); end
    tick();
    m1_arvalid = 0;
    s_rvalid = 1; s_rlast = 1; s_rdata = 32'h77; s_rid = 4'h6;
    #1;
    vec_count++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h77 || m1_rid !== 4'h6) begin err_count++; $display("[TB] FAIL wr_then_rd_data: got %b/%h/%h expected 1/77/6", m1_rvalid, m1_rdata, m1_rid); end
    tick();
    idle_inputs();
  endtask

  task automatic test_w_before_aw;
    m1_awaddr = 32'h40; m1_awvalid = 1; m1_wdata = 32'h55; m1_wlast = 1; m1_wvalid = 1;
    s_awready = 0; s_wready = 1; m1_bready = 1;
    tick();
    vec_count++; if (s_wvalid !== 1'b1 || s_awvalid !== 1'b1 || s_bready !== 1'b0) begin err_count++; $display("[TB] FAIL wa_enter: got w=%b aw=%b bready=%b expected 1 1 0", s_wvalid, s_awvalid, s_bready); end
    tick();
    vec_count++; if (s_wvalid !== 1'b0 || m1_wready !== 1'b0) begin err_count++; $display("[TB] FAIL wa_w_masked: got wvalid=%b wready=%b expected 0 0", s_wvalid, m1_wready); end
    vec_count++; if (s_awvalid !== 1'b1 || s_bready !== 1'b0) begin err_count++; $display("[TB] FAIL wa_wait_aw1: got awvalid=%b bready=%b expected 1 0", s_awvalid, s_bready); end
    tick();
    vec_count++; if (s_wvalid !== 1'b0 || s_bready !== 1'b0) begin err_count++; $display("[TB] FAIL wa_wait_aw2: got wvalid=%b bready=%b expected 0 0", s_wvalid, s_bready); end
    s_awready = 1;
    #1;
    vec_count++; if (m1_awready !== 1'b1) begin err_count++; $display("[TB] FAIL wa_awready: got %b expected 1", m1_awready); end
    tick();
    m1_awvalid = 0; m1_wvalid = 0;
    #1;
    vec_count++; if (s_bready !== 1'b1 || s_awvalid !== 1'b0) begin err_count++; $display("[TB] FAIL wa_wresp: got bready=%b awvalid=%b expected 1 0", s_bready, s_awvalid); end
    s_bvalid = 1;
    tick();
    s_bvalid = 0;
    #1;
    vec_count++; if (s_bready !== 1'b0 || m1_bvalid !== 1'b0) begin err_count++; $display("[TB] FAIL wa_done: got bready=%b bvalid=%b expected 0 0", s_bready, m1_bvalid); end
    idle_inputs();
  endtask

  task automatic test_burst;
    m0_araddr = 32'h2000; m0_arlen = 8'd3; m0_arvalid = 1;
    m1_araddr = 32'h3000; m1_arvalid = 1;
    s_arready = 1; m0_rready = 1; m1_rready = 1;
    tick();
    vec_count++; if (s_arvalid !== 1'b1 || s_araddr !== 32'h2000 || s_arlen !== 8'd3) begin err_count++; $display("[TB] FAIL burst_ar: got %b/%h/%0d expected 1/2000/3", s_arvalid, s_araddr, s_arlen); end
    tick();
    m0_arvalid = 0;
    for (int i = 0; i < 4; i++) begin
      s_rvalid = 1; s_rdata = 32'h1000 + i; s_rlast = (i == 3);
      #1;
      vec_count++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h1000 + i || m0_rlast !== (i == 3)) begin err_count++; $display("[TB] FAIL burst_beat%0d: got %b/%h/%b expected 1/%h/%b", i, m0_rvalid, m0_rdata, m0_rlast, 32'h1000 + i, i == 3); end
      vec_count++; if (s_arvalid !== 1'b0 || m1_rvalid !== 1'b0) begin err_count++; $display("[TB] FAIL burst_hold%0d: got arvalid=%b m1_rvalid=%b expected 0 0", i, s_arvalid, m1_rvalid); end
      tick();
    end
    s_rvalid = 0; s_rlast = 0;
    #1;
    vec_count++; if (s_arvalid !== 1'b0 || m0_rvalid !== 1'b0) begin err_count++; $display("[TB] FAIL burst_idle: got arvalid=%b rvalid=%b expected 0 0", s_arvalid, m0_rvalid); end
    tick();
    vec_count++; if (s_arvalid !== 1'b1 || s_araddr !== 32'h3000) begin err_count++; $display("[TB] FAIL burst_m1_next: got %b/%h expected 1/3000", s_arvalid, s_araddr); end
    tick();
    m1_arvalid = 0;
    s_rvalid = 1; s_rlast = 1; s_rdata = 32'h88;
    #1;
    vec_count++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h88) begin err_count++; $display("[TB] FAIL burst_m1_data: got %b/%h expected 1/88", m1_rvalid, m1_rdata); end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid;
    m0_araddr = 32'h4000; m0_arvalid = 1; s_arready = 1; m0_rready = 1;
    tick();
    tick();
    m0_arvalid = 0;
    s_rvalid = 1; s_rlast = 0; s_rdata = 32'h99;
    #1;
    vec_count++; if (m0_rvalid !== 1'b1) begin err_count++; $display("[TB] FAIL rstmid_pre: got %b expected 1", m0_rvalid); end
    rst = 1;
    tick();
    rst = 0;
    #1;
    vec_count++; if (m0_rvalid !== 1'b0 || s_rready !== 1'b0 || s_arvalid !== 1'b0) begin err_count++; $display("[TB] FAIL rstmid_drop: got rvalid=%b rready=%b arvalid=%b expected 0 0 0", m0_rvalid, s_rready, s_arvalid); end
    s_rvalid = 0;
    m0_arvalid = 1; m1_araddr = 32'h5000; m1_arvalid = 1;
    tick();
    vec_count++; if (s_arvalid !== 1'b1 || s_araddr !== 32'h4000 || m0_arready !== 1'b1) begin err_count++; $display("[TB] FAIL rstmid_last: got %b/%h/%b expected 1/4000/1", s_arvalid, s_araddr, m0_arready); end
    tick();
    m0_arvalid = 0;
    s_rvalid = 1; s_rlast = 1; s_rdata = 32'haa;
    #1;
    vec_count++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'haa) begin err_count++; $display("[TB] FAIL rstmid_resume: got %b/%h expected 1/aa", m0_rvalid, m0_rdata); end
    m1_arvalid = 0;
    tick();
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_m0_read();
    test_round_robin();
    test_write_priority();
    test_w_before_aw();
    test_burst();
    test_reset_mid();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
